demux_stream: RTL and testbench

//  Registered 1-to-NUM_CH stream demultiplexer; parametrised successor of the 1-bit combinational demux_1bit.

---
 rtl/demux_pkg.sv | 32 +++
 rtl/demux_stream_if.sv | 29 ++
 rtl/demux_ch_buf.sv | 60 ++++++
 rtl/demux_stream.sv | 86 ++++++++
 tb/tb_demux_stream.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the demux_stream slice: channel limits,
// per-channel buffer depth and the routing decision of an incoming word.
package demux_pkg;

    localparam int MAX_CH   = 16;
    localparam int CH_DEPTH = 2;
    localparam int CNT_W    = $clog2(CH_DEPTH + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_EMPTY = cnt_t'(0);
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t CNT_FULL  = cnt_t'(CH_DEPTH);

    // Where the word on the input goes if it is accepted this cycle.
    typedef enum logic [1:0] {
        ROUTE_UNI   = 2'd0,
        ROUTE_BCAST = 2'd1,
        ROUTE_DROP  = 2'd2
    } route_e;

    function automatic route_e route_of(input logic bcast, input int unsigned sel,
                                        input int unsigned num_ch);
        if (bcast)
            return ROUTE_BCAST;
        else if (sel >= num_ch)
            return ROUTE_DROP;
        else
            return ROUTE_UNI;
    endfunction

endpackage

// File: rtl/demux_stream_if.sv
// Producer-side stream plus NUM_CH consumer-side streams of the demultiplexer.
// The slave modport is the demux itself; master is the environment around it.
interface demux_stream_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
);

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     sel_err;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );

endinterface

// File: rtl/demux_ch_buf.sv
// Two-entry per-channel FIFO. The head register drives dout directly, so the
// output is fully registered and holds still while the consumer stalls.
module demux_ch_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    cnt_t              count;
    logic              pop;

    assign pop   = valid & ready;
    assign full  = (count == CNT_FULL);
    assign valid = (count != CNT_EMPTY);
    assign dout  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_EMPTY;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == CNT_EMPTY)
                        head <= din;
                    else
                        tail <= din;
                    count <= count + CNT_ONE;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - CNT_ONE;
                end
                2'b11: begin
                    // Count is unchanged; the new word goes behind whatever remains.
                    if (count == CNT_ONE) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-NUM_CH stream demultiplexer with unicast, broadcast and
// out-of-range drop; each channel owns a 2-entry buffer so stalls stay local.
module demux_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_stream_if.slave  bus
);

    localparam int SEL_SPAN = 1 << SEL_W;

    logic                     run;
    logic                     ready;
    logic                     accept;
    logic                     sel_err_q;
    route_e                   route;
    logic [NUM_CH-1:0]        full;
    logic [NUM_CH-1:0]        push;
    logic [SEL_SPAN-1:0]      full_pad;
    logic [NUM_CH-1:0]        valid_w;
    logic [NUM_CH*DATA_W-1:0] data_w;

    always_comb begin
        route = route_of(bus.in_bcast, 32'(bus.in_sel), NUM_CH);
    end

    // Unused select codes read as not-full so the mux index is always in range.
    always_comb begin
        full_pad             = '0;
        full_pad[NUM_CH-1:0] = full;
    end

    // Acceptance depends only on registered buffer state, never on out_ready.
    always_comb begin
        ready = 1'b0;
        if (run) begin
            case (route)
                ROUTE_BCAST: ready = ~|full;
                ROUTE_DROP:  ready = 1'b1;
                default:     ready = ~full_pad[bus.in_sel];
            endcase
        end
    end

    assign accept       = bus.in_valid & ready;
    assign bus.in_ready = ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign push[k] = accept & ((route == ROUTE_BCAST) |
                                   ((route == ROUTE_UNI) & (bus.in_sel == SEL_W'(k))));

        demux_ch_buf #(
            .DATA_W (DATA_W)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .din   (bus.in_data),
            .full  (full[k]),
            .valid (valid_w[k]),
            .ready (bus.out_ready[k]),
            .dout  (data_w[k*DATA_W +: DATA_W])
        );
    end

    assign bus.out_valid = valid_w;
    assign bus.out_data  = data_w;
    assign bus.sel_err   = sel_err_q;

    // run keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            run       <= 1'b1;
            sel_err_q <= accept & (route == ROUTE_DROP);
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Directed table and corner sequences on a 3-channel demux, plus random
// scoreboard runs on 3, 4 and 5 channel instances.
module tb_demux_stream;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_r;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    demux_stream_if #(.DATA_W(8), .NUM_CH(3)) d ();

    demux_stream #(.DATA_W(8), .NUM_CH(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (d)
    );

    logic        pre_rdy;
    logic [2:0]  pre_v;
    logic [23:0] pre_d;

    // Drive at negedge, sample 1 time unit before the rising edge, return 1 after it.
    task automatic cyc(input logic v, input logic b, input logic [1:0] s,
                       input logic [7:0] dat, input logic [2:0] r);
        @(negedge clk);
        d.in_valid  = v;
        d.in_bcast  = b;
        d.in_sel    = s;
        d.in_data   = dat;
        d.out_ready = r;
        #4;
        pre_rdy = d.in_ready;
        pre_v   = d.out_valid;
        pre_d   = d.out_data;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        b;
        logic [1:0]  s;
        logic [7:0]  dat;
        logic [2:0]  rdy;
        logic        exp_rdy;
        logic [2:0]  exp_v;
        logic [23:0] exp_d;
        logic        exp_err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst_r = 1'b0;
        #22 rst_r = 1'b1;
    end

    // Random traffic against a per-channel queue model on several channel counts.
    for (genvar g = 0; g < 3; g++) begin : gen_r
        localparam int NC = 3 + g;
        localparam int SW = $clog2(NC);

        demux_stream_if #(.DATA_W(8), .NUM_CH(NC)) rb ();

        demux_stream #(.DATA_W(8), .NUM_CH(NC)) u_r (
            .clk   (clk),
            .rst_n (rst_r),
            .bus   (rb)
        );

        bit         done = 1'b0;
        logic [7:0] q[NC][$];

        initial begin : drv
            int         sent;
            int         cnt;
            int         r;
            int         pend;
            bit         prev_oob;
            logic [7:0] exp_w;
            rb.in_valid  = 1'b0;
            rb.in_data   = '0;
            rb.in_sel    = '0;
            rb.in_bcast  = 1'b0;
            rb.out_ready = '0;
            sent = 0;
            cnt = 0;
            prev_oob = 1'b0;
            wait (rst_r);
            @(posedge clk);
            while (cnt < 20000) begin
                @(negedge clk);
                cnt++;
                if (sent < 1000) begin
                    r = $urandom_range(0, 15);
                    rb.in_valid  = ($urandom_range(0, 3) != 0);
                    rb.in_data   = 8'(sent);
                    rb.in_bcast  = (r == 0);
                    rb.in_sel    = SW'($urandom_range(0, NC - 1));
                    if (r == 1 && (1 << SW) > NC)
                        rb.in_sel = SW'(NC);
                    rb.out_ready = NC'($urandom);
                end else begin
                    rb.in_valid  = 1'b0;
                    rb.out_ready = '1;
                end
                #4;
                chk($sformatf("r%0d_sel_err", NC), 32'(rb.sel_err), 32'(prev_oob));
                prev_oob = 1'b0;
                for (int j = 0; j < NC; j++) begin
                    if (rb.out_valid[j] && rb.out_ready[j]) begin
                        if (q[j].size() == 0) begin
                            chk($sformatf("r%0d_spurious_ch%0d", NC, j), 32'd1, 32'd0);
                        end else begin
                            exp_w = q[j].pop_front();
                            chk($sformatf("r%0d_data_ch%0d", NC, j),
                                32'(rb.out_data[j*8 +: 8]), 32'(exp_w));
                        end
                    end
                end
                if (rb.in_valid && rb.in_ready) begin
                    if (rb.in_bcast) begin
                        for (int j = 0; j < NC; j++) q[j].push_back(rb.in_data);
                    end else if (32'(rb.in_sel) >= NC) begin
                        prev_oob = 1'b1;
                    end else begin
                        q[rb.in_sel].push_back(rb.in_data);
                    end
                    sent++;
                end
                pend = 0;
                for (int j = 0; j < NC; j++) pend += q[j].size();
                if (sent >= 1000 && pend == 0) break;
            end
            chk($sformatf("r%0d_words_sent", NC), 32'(sent), 32'd1000);
            pend = 0;
            for (int j = 0; j < NC; j++) pend += q[j].size();
            chk($sformatf("r%0d_queues_drained", NC), 32'(pend), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        int         si;
        int         pi;
        logic [7:0] dq[5];
        logic [23:0] mask;

        tbl[0]  = '{1'b1, 1'b0, 2'd1, 8'hA5, 3'b111, 1'b1, 3'b010, 24'h00A500, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'h5A, 3'b111, 1'b1, 3'b001, 24'h00005A, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 2'd0, 8'h3C, 3'b111, 1'b1, 3'b111, 24'h3C3C3C, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'd3, 8'hFF, 3'b111, 1'b1, 3'b000, 24'h000000, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 2'd2, 8'h77, 3'b000, 1'b1, 3'b100, 24'h770000, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'd2, 8'h88, 3'b000, 1'b1, 3'b100, 24'h770000, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'd2, 8'h99, 3'b000, 1'b0, 3'b100, 24'h770000, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 8'h11, 3'b000, 1'b1, 3'b101, 24'h770011, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 2'd0, 8'h22, 3'b000, 1'b0, 3'b101, 24'h770011, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 2'd0, 8'h22, 3'b100, 1'b0, 3'b101, 24'h880011, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'd0, 8'h22, 3'b000, 1'b1, 3'b111, 24'h882211, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 2'd1, 8'h33, 3'b111, 1'b1, 3'b111, 24'h223322, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 24'h000000, 1'b0};

        d.in_valid  = 1'b0;
        d.in_bcast  = 1'b0;
        d.in_sel    = '0;
        d.in_data   = '0;
        d.out_ready = '0;
        rst_n       = 1'b0;

        #3;
        chk("reset_out_valid", 32'(d.out_valid), 32'd0);
        chk("reset_out_data", 32'(d.out_data), 32'd0);
        chk("reset_sel_err", 32'(d.sel_err), 32'd0);
        chk("reset_in_ready", 32'(d.in_ready), 32'd0);
        #19 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("release_in_ready", 32'(d.in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].dat, tbl[i].rdy);
            mask = {{8{tbl[i].exp_v[2]}}, {8{tbl[i].exp_v[1]}}, {8{tbl[i].exp_v[0]}}};
            chk($sformatf("tbl%0d_in_ready", i), 32'(pre_rdy), 32'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(d.out_valid), 32'(tbl[i].exp_v));
            chk($sformatf("tbl%0d_out_data", i), 32'(d.out_data & mask), 32'(tbl[i].exp_d));
            chk($sformatf("tbl%0d_sel_err", i), 32'(d.sel_err), 32'(tbl[i].exp_err));
        end

        // Back-to-back words to one channel at full rate.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 2'd2, 8'(i), 3'b111);
            chk($sformatf("b2b%0d_in_ready", i), 32'(pre_rdy), 32'd1);
            chk($sformatf("b2b%0d_valid", i), 32'(d.out_valid), 32'b100);
            chk($sformatf("b2b%0d_data", i), 32'(d.out_data[23:16]), 32'(i));
        end
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 3'b111);
        chk("b2b_drained", 32'(d.out_valid), 32'd0);

        // Third word to a stalled channel is refused, then release drains in order.
        cyc(1'b1, 1'b0, 2'd0, 8'h11, 3'b000);
        cyc(1'b1, 1'b0, 2'd0, 8'h22, 3'b000);
        cyc(1'b1, 1'b0, 2'd0, 8'h33, 3'b000);
        chk("bp_third_refused", 32'(pre_rdy), 32'd0);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 3'b001);
        chk("bp_first_out", 32'({pre_v[0], pre_d[7:0]}), 32'h111);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 3'b001);
        chk("bp_second_out", 32'({pre_v[0], pre_d[7:0]}), 32'h122);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 3'b001);
        chk("bp_empty", 32'(pre_v), 32'd0);

        // Full channel drained while the producer keeps pushing.
        dq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        cyc(1'b1, 1'b0, 2'd0, dq[0], 3'b000);
        cyc(1'b1, 1'b0, 2'd0, dq[1], 3'b000);
        si = 2;
        pi = 0;
        for (int t = 0; t < 12 && pi < 5; t++) begin
            cyc(si < 5, 1'b0, 2'd0, (si < 5) ? dq[si] : 8'h00, 3'b001);
            if (t == 0) chk("full_in_ready", 32'(pre_rdy), 32'd0);
            if (pre_v[0]) begin
                chk($sformatf("full_pop%0d", pi), 32'(pre_d[7:0]), 32'(dq[pi]));
                pi++;
            end
            if (si < 5 && pre_rdy) si++;
        end
        chk("full_all_popped", 32'(pi), 32'd5);
        chk("full_all_pushed", 32'(si), 32'd5);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 3'b001);
        chk("full_no_dup", 32'(pre_v), 32'd0);

        // Reset in the middle of traffic with a sel_err pulse pending.
        cyc(1'b1, 1'b0, 2'd1, 8'h55, 3'b000);
        cyc(1'b1, 1'b0, 2'd3, 8'hFF, 3'b000);
        chk("mid_sel_err", 32'(d.sel_err), 32'd1);
        chk("mid_valid", 32'(d.out_valid), 32'b010);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 32'(d.out_valid), 32'd0);
        chk("mid_reset_sel_err", 32'(d.sel_err), 32'd0);
        chk("mid_reset_data", 32'(d.out_data), 32'd0);
        chk("mid_reset_in_ready", 32'(d.in_ready), 32'd0);
        d.in_valid = 1'b0;
        d.in_sel   = 2'd1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_release_in_ready", 32'(d.in_ready), 32'd1);
        chk("mid_release_valid", 32'(d.out_valid), 32'd0);

        for (int t = 0; t < 25000; t++) begin
            if (gen_r[0].done && gen_r[1].done && gen_r[2].done) break;
            @(posedge clk);
        end
        chk("random_runs_done", 32'(gen_r[0].done & gen_r[1].done & gen_r[2].done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
